// File: rtl/bus_downsizer_pkg.sv
// Shared constants, lane mapping helpers and state type for the 128->32 bit Wishbone downsizer.
package bus_downsizer_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 32;
    localparam int unsigned SEL_W  = 4;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    // Lane 0 is the most-significant word, so the slice base is (3 - lane) * width.
    function automatic logic [6:0] lane_data_lsb(input logic [1:0] lane);
        return {~lane, 5'b0};
    endfunction

    function automatic logic [3:0] lane_sel_lsb(input logic [1:0] lane);
        return {~lane, 2'b0};
    endfunction

endpackage

// File: rtl/bus_downsizer_lanepick.sv
// Picks the lowest-numbered lane still set in a lane mask; flags when none remain.
module bus_downsizer_lanepick
    import bus_downsizer_pkg::*;
(
    input  logic [LANES-1:0] mask_i,
    output logic [1:0]       lane_o,
    output logic             none_o
);

    always_comb begin
        lane_o = 2'd0;
        none_o = 1'b1;
        for (int i = 0; i < int'(LANES); i++) begin
            if (mask_i[i] && none_o) begin
                lane_o = 2'(i);
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bus_downsizer.sv
// Wishbone pipelined bridge: splits one 128-bit request into up to four 32-bit requests
// and assembles the narrow replies into a single wide ack.
module bus_downsizer
    import bus_downsizer_pkg::*;
#(
    parameter int unsigned AWIN  = 28,
    parameter int unsigned DWIN  = 128,
    parameter int unsigned DWOUT = 32,
    parameter int unsigned AWOUT = AWIN + 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_s_cyc,
    input  logic              i_s_stb,
    input  logic              i_s_we,
    input  logic [AWIN-1:0]   i_s_addr,
    input  logic [DWIN-1:0]   i_s_data,
    input  logic [DWIN/8-1:0] i_s_sel,
    output logic              o_s_ack,
    output logic              o_s_stall,
    output logic [DWIN-1:0]   o_s_data,
    output logic              o_s_err,
    output logic              o_m_cyc,
    output logic              o_m_stb,
    output logic              o_m_we,
    output logic [AWOUT-1:0]  o_m_addr,
    output logic [DWOUT-1:0]  o_m_data,
    output logic [SEL_W-1:0]  o_m_sel,
    input  logic              i_m_ack,
    input  logic              i_m_stall,
    input  logic [DWOUT-1:0]  i_m_data,
    input  logic              i_m_err
);

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [AWIN-1:0]     addr_q, addr_d;
    logic [DWIN-1:0]     data_q, data_d;
    logic [DWIN/8-1:0]   sel_q, sel_d;
    logic [LANES-1:0]    issue_mask_q, issue_mask_d;
    logic [LANES-1:0]    ack_mask_q, ack_mask_d;
    logic [2:0]          issue_cnt_q, issue_cnt_d;
    logic [2:0]          ack_cnt_q, ack_cnt_d;
    logic [2:0]          n_act_q, n_act_d;
    logic [DWIN-1:0]     s_data_q, s_data_d;
    logic                err_q, err_d;

    logic [LANES-1:0]    act_mask;
    logic [2:0]          act_cnt;
    logic [1:0]          issue_lane, ack_lane;
    logic                issue_none, ack_none;
    logic                busy, accept, m_stb, issue_fire, ack_fire;

    bus_downsizer_lanepick u_issue_pick (
        .mask_i (issue_mask_q),
        .lane_o (issue_lane),
        .none_o (issue_none)
    );

    // Acks complete in issue order, so the oldest unacked lane receives the data.
    bus_downsizer_lanepick u_ack_pick (
        .mask_i (ack_mask_q),
        .lane_o (ack_lane),
        .none_o (ack_none)
    );

    always_comb begin
        act_mask = '0;
        act_cnt  = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            act_mask[k] = |i_s_sel[lane_sel_lsb(2'(k)) +: SEL_W];
            act_cnt     = act_cnt + {2'b0, act_mask[k]};
        end
    end

    assign busy       = (state_q == StIssue) || (state_q == StWait);
    assign accept     = ((state_q == StIdle) || (state_q == StDone)) && i_s_cyc && i_s_stb;
    assign m_stb      = (state_q == StIssue) && !issue_none;
    assign issue_fire = m_stb && !i_m_stall;
    assign ack_fire   = busy && i_m_ack && !ack_none;

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        data_d       = data_q;
        sel_d        = sel_q;
        issue_mask_d = issue_mask_q;
        ack_mask_d   = ack_mask_q;
        issue_cnt_d  = issue_cnt_q;
        ack_cnt_d    = ack_cnt_q;
        n_act_d      = n_act_q;
        s_data_d     = s_data_q;
        err_d        = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    we_d         = i_s_we;
                    addr_d       = i_s_addr;
                    data_d       = i_s_data;
                    sel_d        = i_s_sel;
                    issue_mask_d = act_mask;
                    ack_mask_d   = act_mask;
                    issue_cnt_d  = '0;
                    ack_cnt_d    = '0;
                    n_act_d      = act_cnt;
                    s_data_d     = '0;
                    state_d      = (act_mask == '0) ? StDone : StIssue;
                end
            end
            StIssue, StWait: begin
                if (!i_s_cyc) begin
                    state_d = StIdle;
                end else if (i_m_err) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    if (ack_fire) begin
                        s_data_d[lane_data_lsb(ack_lane) +: LANE_W] = i_m_data;
                        ack_mask_d[ack_lane] = 1'b0;
                        ack_cnt_d            = ack_cnt_q + 3'd1;
                    end
                    if (issue_fire) begin
                        issue_mask_d[issue_lane] = 1'b0;
                        issue_cnt_d              = issue_cnt_q + 3'd1;
                    end
                    if (issue_cnt_d == n_act_q) begin
                        state_d = (ack_cnt_d == n_act_q) ? StDone : StWait;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= StIdle;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            sel_q        <= '0;
            issue_mask_q <= '0;
            ack_mask_q   <= '0;
            issue_cnt_q  <= '0;
            ack_cnt_q    <= '0;
            n_act_q      <= '0;
            s_data_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            sel_q        <= sel_d;
            issue_mask_q <= issue_mask_d;
            ack_mask_q   <= ack_mask_d;
            issue_cnt_q  <= issue_cnt_d;
            ack_cnt_q    <= ack_cnt_d;
            n_act_q      <= n_act_d;
            s_data_q     <= s_data_d;
            err_q        <= err_d;
        end
    end

    assign o_s_ack   = (state_q == StDone);
    assign o_s_stall = busy;
    assign o_s_data  = s_data_q;
    assign o_s_err   = err_q;
    assign o_m_cyc   = busy;
    assign o_m_stb   = m_stb;
    assign o_m_we    = busy && we_q;
    assign o_m_addr  = m_stb ? {addr_q, issue_lane} : '0;
    assign o_m_data  = m_stb ? data_q[lane_data_lsb(issue_lane) +: LANE_W] : '0;
    assign o_m_sel   = m_stb ? sel_q[lane_sel_lsb(issue_lane) +: SEL_W] : '0;

endmodule

// File: tb/tb_bus_downsizer.sv
// Self-checking bench for bus_downsizer: table vectors, directed corner sequences and
// randomized requests against a lane-level reference model and a narrow slave model.
module tb_bus_downsizer;

    localparam int AWIN  = 28;
    localparam int AWOUT = 30;

    logic          clk = 1'b0;
    logic          i_reset, i_s_cyc, i_s_stb, i_s_we;
    logic [27:0]   i_s_addr;
    logic [127:0]  i_s_data;
    logic [15:0]   i_s_sel;
    logic          o_s_ack, o_s_stall, o_s_err;
    logic [127:0]  o_s_data;
    logic          o_m_cyc, o_m_stb, o_m_we;
    logic [29:0]   o_m_addr;
    logic [31:0]   o_m_data;
    logic [3:0]    o_m_sel;
    logic          i_m_ack, i_m_stall, i_m_err;
    logic [31:0]   i_m_data;

    always #5 clk = ~clk;

    bus_downsizer #(.AWIN(AWIN)) dut (
        .i_clk     (clk),
        .i_reset   (i_reset),
        .i_s_cyc   (i_s_cyc),
        .i_s_stb   (i_s_stb),
        .i_s_we    (i_s_we),
        .i_s_addr  (i_s_addr),
        .i_s_data  (i_s_data),
        .i_s_sel   (i_s_sel),
        .o_s_ack   (o_s_ack),
        .o_s_stall (o_s_stall),
        .o_s_data  (o_s_data),
        .o_s_err   (o_s_err),
        .o_m_cyc   (o_m_cyc),
        .o_m_stb   (o_m_stb),
        .o_m_we    (o_m_we),
        .o_m_addr  (o_m_addr),
        .o_m_data  (o_m_data),
        .o_m_sel   (o_m_sel),
        .i_m_ack   (i_m_ack),
        .i_m_stall (i_m_stall),
        .i_m_data  (i_m_data),
        .i_m_err   (i_m_err)
    );

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic        we;
    } nx_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    typedef struct {
        logic         we;
        logic [27:0]  addr;
        logic [127:0] data;
        logic [15:0]  sel;
        logic [127:0] exp_data;
        int           exp_lat;
    } vec_t;

    int     checks = 0;
    int     failures = 0;
    int     cyc_n = 0;
    nx_t    log_q[$];
    nx_t    exp_q[$];
    pend_t  pend_q[$];
    int     stall_pct = 0, ack_dly = 0, ack_dly_max = 0, stall_left = 0, err_idx = -1, stray = 0;
    int     acks_sent = 0;
    logic   prev_stalled = 1'b0;
    logic [66:0] snap;

    // Narrow slave contents: lane k of word 0x10 reads (k+1)*0x11111111.
    function automatic logic [31:0] mem_val(input logic [29:0] a);
        logic [31:0] base;
        base = 32'h1111_1111 * (32'(a[1:0]) + 32'd1);
        return base ^ (32'(a[29:2]) - 32'h10);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_exp(input logic we, input logic [27:0] addr, input logic [127:0] data,
                           input logic [15:0] sel);
        for (int k = 0; k < 4; k++) begin
            logic [3:0] s;
            s = sel[15-4*k -: 4];
            if (s != 4'h0) exp_q.push_back('{addr: {addr, 2'(k)}, data: data[127-32*k -: 32],
                                             sel: s, we: we});
        end
    endtask

    function automatic logic [127:0] exp_rdata(input logic [27:0] addr, input logic [15:0] sel);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 4; k++)
            if (sel[15-4*k -: 4] != 4'h0) r[127-32*k -: 32] = mem_val({addr, 2'(k)});
        return r;
    endfunction

    task automatic check_log(input string name);
        check({name, "_count"}, 128'(log_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check(name, {log_q[i].we, log_q[i].sel, log_q[i].addr, log_q[i].data},
                  {exp_q[i].we, exp_q[i].sel, exp_q[i].addr, exp_q[i].data});
    endtask

    task automatic do_req(input logic we, input logic [27:0] addr, input logic [127:0] data,
                          input logic [15:0] sel, output int lat, output logic got_ack,
                          output logic got_err, output logic [127:0] rdata);
        int   t;
        logic stall_bad;
        log_q.delete();
        @(posedge clk); #1;
        i_s_cyc = 1'b1; i_s_stb = 1'b1; i_s_we = we;
        i_s_addr = addr; i_s_data = data; i_s_sel = sel;
        t = 0;
        while (o_s_stall && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
        i_s_stb = 1'b0;
        lat = 1; stall_bad = 1'b0;
        while (!o_s_ack && !o_s_err && lat < 200) begin
            if (!o_s_stall) stall_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        got_ack = o_s_ack; got_err = o_s_err; rdata = o_s_data;
        check("s_stall_while_busy", 128'(stall_bad), 128'(0));
        check("m_cyc_at_end", 128'(o_m_cyc), 128'(0));
        if (got_ack) check("s_stall_in_ack_cycle", 128'(o_s_stall), 128'(0));
        @(posedge clk); #1;
        i_s_cyc = 1'b0;
        if (got_err) check("err_single_cycle", 128'(o_s_err), 128'(0));
    endtask

    // Narrow slave: stall, in-order acks with configurable delay, error and stray-ack injection.
    initial begin
        pend_t p;
        i_m_ack = 1'b0; i_m_err = 1'b0; i_m_stall = 1'b0; i_m_data = '0;
        forever begin
            @(posedge clk); #1;
            i_m_ack = 1'b0; i_m_err = 1'b0; i_m_data = '0;
            if (stray > 0) begin
                i_m_ack = 1'b1; i_m_data = 32'hDEAD_BEEF;
                stray--;
            end else if (pend_q.size() > 0 && pend_q[0].due <= cyc_n) begin
                p = pend_q.pop_front();
                i_m_ack = 1'b1; i_m_data = p.data;
                if (acks_sent == err_idx) i_m_err = 1'b1;
                acks_sent++;
            end
            if (o_m_stb && stall_left > 0) begin
                i_m_stall = 1'b1;
                stall_left--;
            end else begin
                i_m_stall = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
            end
            @(negedge clk);
            if (i_reset || !o_m_cyc) begin
                pend_q.delete();
                acks_sent = 0;
                prev_stalled = 1'b0;
            end else begin
                if (prev_stalled && o_m_stb)
                    check("m_held_during_stall", {o_m_we, o_m_sel, o_m_addr, o_m_data}, snap);
                if (o_m_stb && !i_m_stall) begin
                    log_q.push_back('{addr: o_m_addr, data: o_m_data, sel: o_m_sel, we: o_m_we});
                    pend_q.push_back('{due: cyc_n + 1 +
                                      (ack_dly_max > 0 ? int'($urandom_range(ack_dly_max)) : ack_dly),
                                      data: mem_val(o_m_addr)});
                end
                prev_stalled = o_m_stb && i_m_stall;
                snap = {o_m_we, o_m_sel, o_m_addr, o_m_data};
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc_n++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t         vecs[5];
    int           lat, t, acc2, ack1;
    logic         got_ack, got_err;
    logic [127:0] rdata, r1;

    initial begin
        vecs[0] = '{1'b0, 28'h10, 128'h0, 16'hFFFF,
                    128'h11111111_22222222_33333333_44444444, 6};
        vecs[1] = '{1'b1, 28'h5, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, 16'h0F0F,
                    128'h00000000_DDDDDDD7_00000000_BBBBBBB1, 4};
        vecs[2] = '{1'b1, 28'h123, 128'h1234, 16'h0000, 128'h0, 1};
        vecs[3] = '{1'b0, 28'h10, 128'h0, 16'h8001,
                    128'h11111111_00000000_00000000_44444444, 4};
        vecs[4] = '{1'b0, 28'h10, 128'h0, 16'h00F0,
                    128'h00000000_00000000_33333333_00000000, 3};

        i_reset = 1'b1; i_s_cyc = 1'b0; i_s_stb = 1'b0; i_s_we = 1'b0;
        i_s_addr = '0; i_s_data = '0; i_s_sel = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {o_s_ack, o_s_stall, o_s_err, o_m_cyc, o_m_stb, o_m_we,
                                o_m_addr, o_m_sel, o_m_data}, 128'(0));
        check("reset_s_data", o_s_data, 128'(0));
        i_reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            exp_q.delete();
            add_exp(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].sel);
            do_req(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].sel, lat, got_ack, got_err, rdata);
            check($sformatf("vec%0d_ack", i), 128'({got_ack, got_err}), 128'(2'b10));
            check($sformatf("vec%0d_data", i), rdata, vecs[i].exp_data);
            check($sformatf("vec%0d_latency", i), 128'(lat), 128'(vecs[i].exp_lat));
            check_log($sformatf("vec%0d_narrow", i));
        end

        // First lane stalled 3 cycles while a second wide request waits on the bus.
        exp_q.delete();
        add_exp(1'b0, 28'h10, 128'h0, 16'hFFFF);
        add_exp(1'b0, 28'h20, 128'h0, 16'hF00F);
        log_q.delete();
        stall_left = 3;
        @(posedge clk); #1;
        i_s_cyc = 1'b1; i_s_stb = 1'b1; i_s_we = 1'b0; i_s_addr = 28'h10; i_s_sel = 16'hFFFF;
        @(posedge clk); #1;
        i_s_addr = 28'h20; i_s_sel = 16'hF00F;
        t = 1; acc2 = -1; ack1 = -1; r1 = '0;
        while (t < 100 && acc2 < 0) begin
            if (o_s_ack && ack1 < 0) begin
                ack1 = t;
                r1 = o_s_data;
            end
            if (!o_s_stall) acc2 = t;
            if (acc2 < 0) begin
                @(posedge clk); #1;
                t++;
            end
        end
        check("stall_req1_latency", 128'(ack1), 128'(9));
        check("req2_accepted_at_ack", 128'(acc2), 128'(ack1));
        check("stall_req1_data", r1, exp_rdata(28'h10, 16'hFFFF));
        @(posedge clk); #1;
        i_s_stb = 1'b0;
        t = 0;
        while (!o_s_ack && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("req2_ack", 128'(o_s_ack), 128'(1));
        check("req2_data", o_s_data, exp_rdata(28'h20, 16'hF00F));
        check_log("pipelined_narrow");
        @(posedge clk); #1;
        i_s_cyc = 1'b0;

        // Error on the second narrow ack, together with ack: error wins.
        err_idx = 1;
        do_req(1'b0, 28'h44, 128'h0, 16'hFFFF, lat, got_ack, got_err, rdata);
        check("err_seen_no_ack", 128'({got_ack, got_err}), 128'(2'b01));
        err_idx = -1;
        exp_q.delete();
        add_exp(1'b0, 28'h45, 128'h0, 16'hFFFF);
        do_req(1'b0, 28'h45, 128'h0, 16'hFFFF, lat, got_ack, got_err, rdata);
        check("after_err_ack", 128'({got_ack, got_err}), 128'(2'b10));
        check("after_err_data", rdata, exp_rdata(28'h45, 16'hFFFF));
        check_log("after_err_narrow");

        // i_s_cyc dropped after two narrow lanes were issued, then stray acks.
        ack_dly = 2;
        log_q.delete();
        @(posedge clk); #1;
        i_s_cyc = 1'b1; i_s_stb = 1'b1; i_s_we = 1'b1; i_s_addr = 28'h30; i_s_sel = 16'hFFFF;
        i_s_data = 128'h01020304_05060708_090A0B0C_0D0E0F10;
        @(posedge clk); #1;
        i_s_stb = 1'b0;
        t = 0;
        while (log_q.size() < 2 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("abort_two_issued", 128'(log_q.size()), 128'(2));
        i_s_cyc = 1'b0;
        stray = 3;
        @(posedge clk); #1;
        check("abort_outputs", {o_m_cyc, o_m_stb, o_s_ack, o_s_err, o_s_stall}, 128'(0));
        got_ack = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            got_ack = got_ack | o_s_ack | o_m_cyc | o_s_err;
        end
        check("abort_stray_ignored", 128'(got_ack), 128'(0));

        // Reset asserted while waiting for narrow acks.
        log_q.delete();
        @(posedge clk); #1;
        i_s_cyc = 1'b1; i_s_stb = 1'b1; i_s_we = 1'b0; i_s_addr = 28'h10; i_s_sel = 16'hFFFF;
        @(posedge clk); #1;
        i_s_stb = 1'b0;
        t = 0;
        while (log_q.size() < 4 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("reset_wait_reached", 128'(o_m_cyc && !o_m_stb), 128'(1));
        i_reset = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0;
        i_s_cyc = 1'b0;
        check("midwait_reset_outputs", {o_s_ack, o_s_stall, o_s_err, o_m_cyc, o_m_stb, o_m_we,
                                        o_m_addr, o_m_sel, o_m_data}, 128'(0));
        check("midwait_reset_s_data", o_s_data, 128'(0));
        stray = 3;
        got_ack = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            got_ack = got_ack | o_s_ack | o_m_cyc | o_s_err;
        end
        check("reset_stray_ignored", 128'(got_ack), 128'(0));
        exp_q.delete();
        add_exp(1'b0, 28'h10, 128'h0, 16'hFFFF);
        do_req(1'b0, 28'h10, 128'h0, 16'hFFFF, lat, got_ack, got_err, rdata);
        check("after_reset_ack", 128'({got_ack, got_err}), 128'(2'b10));
        check("after_reset_data", rdata, exp_rdata(28'h10, 16'hFFFF));
        check_log("after_reset_narrow");

        // Randomized requests with random narrow stalls and ack delays.
        stall_pct = 25; ack_dly = 0; ack_dly_max = 2;
        for (int n = 0; n < 40; n++) begin
            logic         we;
            logic [27:0]  a;
            logic [127:0] d;
            logic [15:0]  s;
            we = 1'($urandom);
            a  = 28'($urandom);
            d  = {$urandom, $urandom, $urandom, $urandom};
            s  = '0;
            for (int k = 0; k < 4; k++)
                if ($urandom_range(2) != 0) s[4*k +: 4] = 4'($urandom_range(15, 1));
            exp_q.delete();
            add_exp(we, a, d, s);
            do_req(we, a, d, s, lat, got_ack, got_err, rdata);
            check($sformatf("rand%0d_ack", n), 128'({got_ack, got_err}), 128'(2'b10));
            check($sformatf("rand%0d_data", n), rdata, exp_rdata(a, s));
            check_log($sformatf("rand%0d_narrow", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
